// File: rtl/arb_pkg.sv
// Shared defaults, types and helpers for the request-FIFO wrapper around the
// 4-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ID_W   = $clog2(N_REQ);

  typedef logic [DATA_W-1:0] payload_t;

  // OR-reduces the index of every set bit; exact only for one-hot inputs.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_chan_fifo.sv
// Single-channel payload FIFO; storage is left unreset, only pointers and the
// occupancy count are cleared.
module arb_chan_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q, count_d;
  logic          pushOk, popOk;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/arb_req_fifo.sv
// Per-requester input queues feeding the round-robin arbiter, with the grant
// check, registered valid/ready output stage and sticky protocol-error flag.
module arb_req_fifo #(
  parameter int N_REQ  = arb_pkg::N_REQ,
  parameter int DATA_W = arb_pkg::DATA_W,
  parameter int DEPTH  = arb_pkg::DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic [N_REQ-1:0]                 in_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0]     in_data,
  output logic [N_REQ-1:0]                 in_ready,
  output logic [N_REQ-1:0]                 request,
  input  logic [N_REQ-1:0]                 grant,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic [$clog2(N_REQ)-1:0]         out_id,
  input  logic                             out_ready,
  output logic                             err
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0][DATA_W-1:0] headData;
  logic [N_REQ-1:0]             empty, full, pushVec, popVec;
  logic                         multiHot, oneHot, grantBad, slotFree;
  logic [ID_W-1:0]              grantIdx;

  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [ID_W-1:0]   outId_q, outId_d;
  logic              err_q, err_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_chan
    arb_chan_fifo #(.DW(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push_i  (pushVec[i]),
      .pop_i   (popVec[i]),
      .data_i  (in_data[i]),
      .data_o  (headData[i]),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );
  end

  assign in_ready = ~full;
  assign request  = ~empty;
  assign pushVec  = in_valid & in_ready;

  // A grant only pops when it is one-hot, aimed at a non-empty queue, and the
  // output slot is free; anything else is either held off or flagged.
  assign multiHot = |(grant & (grant - N_REQ'(1)));
  assign oneHot   = (grant != '0) && !multiHot;
  assign grantBad = |(grant & ~request);
  assign slotFree = !outValid_q || out_ready;
  assign popVec   = grant & request & {N_REQ{oneHot && slotFree}};
  assign grantIdx = arb_pkg::onehot_to_idx(grant);

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outId_d    = outId_q;
    err_d      = err_q | multiHot | grantBad;
    if (|popVec) begin
      outValid_d = 1'b1;
      outData_d  = headData[grantIdx];
      outId_d    = grantIdx;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outId_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outId_q    <= outId_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_id    = outId_q;
  assign err       = err_q;

endmodule

// File: tb/tb_arb_req_fifo.sv
// Directed bench for arb_req_fifo: the bench plays the arbiter, queues the
// expected output beats, and a negedge monitor scores every accepted beat.
module tb_arb_req_fifo;

  localparam int N  = 4;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_b = 1'b0;
  logic [N-1:0]         in_valid = '0;
  logic [N-1:0][DW-1:0] in_data = '0;
  logic [N-1:0]         in_ready;
  logic [N-1:0]         request;
  logic [N-1:0]         grant = '0;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [1:0]           out_id;
  logic                 out_ready = 1'b1;
  logic                 err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t expQ[$];

  arb_req_fifo #(.N_REQ(N), .DATA_W(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .request   (request),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [1:0] id, input logic [DW-1:0] data);
    expQ.push_back({id, data});
  endtask

  // Channel i sees payload d + 0x10*i so simultaneous pushes stay distinct.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [DW-1:0] d,
                               input logic [N-1:0] g, input logic rdy);
    in_valid = v;
    for (int i = 0; i < N; i++) in_data[i] = d + DW'(i * 16);
    grant     = g;
    out_ready = rdy;
    step();
  endtask

  // Scoreboard monitor: every beat accepted downstream must match the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_b && out_valid && out_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got id=%0d data=%0h, expected no output", out_id, out_data);
      end else begin
        e = expQ.pop_front();
        if ({out_id, out_data} !== e) begin
          errors++;
          $display("[TB] FAIL beat: got id=%0d data=%0h, expected id=%0d data=%0h",
                   out_id, out_data, e.id, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    logic [DW-1:0] drainVals [4];
    drainVals[0] = 8'h52;
    drainVals[1] = 8'h53;
    drainVals[2] = 8'h55;
    drainVals[3] = 8'h56;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    step();
    $display("[TB] reset and idle");
    checkOutput("reset_request", request, 4'b0000);
    checkOutput("reset_in_ready", in_ready, 4'b1111);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_data", out_data, 8'h00);
    checkOutput("reset_out_id", out_id, 2'd0);
    checkOutput("reset_err", err, 1'b0);

    $display("[TB] single push on channel 0");
    applyStimulus(4'b0001, 8'hA5, 4'b0000, 1'b1);
    checkOutput("single_request", request, 4'b0001);
    pushExp(2'd0, 8'hA5);
    applyStimulus(4'b0000, 8'h00, 4'b0001, 1'b1);
    checkOutput("single_out_valid", out_valid, 1'b1);
    checkOutput("single_request_cleared", request, 4'b0000);
    applyStimulus(4'b0000, 8'h00, 4'b0000, 1'b1);
    checkOutput("single_out_valid_drop", out_valid, 1'b0);

    $display("[TB] alternating grants on channels 0 and 1");
    for (int k = 0; k < 3; k++) applyStimulus(4'b0011, 8'h10 + DW'(k), 4'b0000, 1'b1);
    checkOutput("rr_request_loaded", request, 4'b0011);
    for (int k = 0; k < 6; k++) begin
      pushExp(2'(k % 2), ((k % 2) != 0 ? 8'h20 : 8'h10) + DW'(k / 2));
      applyStimulus(4'b0000, 8'h00, (k % 2) != 0 ? 4'b0010 : 4'b0001, 1'b1);
      checkOutput("rr_out_valid", out_valid, 1'b1);
    end
    applyStimulus(4'b0000, 8'h00, 4'b0000, 1'b1);
    checkOutput("rr_request_drained", request, 4'b0000);

    $display("[TB] backpressure");
    applyStimulus(4'b0011, 8'h30, 4'b0000, 1'b1);
    applyStimulus(4'b0001, 8'h31, 4'b0000, 1'b1);
    pushExp(2'd0, 8'h30);
    applyStimulus(4'b0000, 8'h00, 4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0000, 8'h00, (k % 2) != 0 ? 4'b0001 : 4'b0010, 1'b0);
      checkOutput("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_out_data", out_data, 8'h30);
      checkOutput("bp_out_id", out_id, 2'd0);
      checkOutput("bp_request", request, 4'b0011);
      checkOutput("bp_err", err, 1'b0);
    end
    pushExp(2'd1, 8'h40);
    applyStimulus(4'b0000, 8'h00, 4'b0010, 1'b1);
    pushExp(2'd0, 8'h31);
    applyStimulus(4'b0000, 8'h00, 4'b0001, 1'b1);
    applyStimulus(4'b0000, 8'h00, 4'b0000, 1'b1);
    checkOutput("bp_request_drained", request, 4'b0000);

    $display("[TB] fill channel 2, overflow, wrap");
    for (int k = 0; k < 4; k++) applyStimulus(4'b0100, 8'h30 + DW'(k), 4'b0000, 1'b1);
    checkOutput("full_in_ready", in_ready, 4'b1011);
    applyStimulus(4'b0100, 8'h34, 4'b0000, 1'b1);
    checkOutput("overflow_in_ready", in_ready, 4'b1011);
    pushExp(2'd2, 8'h50);
    applyStimulus(4'b0000, 8'h00, 4'b0100, 1'b1);
    checkOutput("after_pop_in_ready", in_ready, 4'b1111);
    pushExp(2'd2, 8'h51);
    applyStimulus(4'b0100, 8'h35, 4'b0100, 1'b1);
    checkOutput("push_pop_in_ready", in_ready, 4'b1111);
    applyStimulus(4'b0100, 8'h36, 4'b0000, 1'b1);
    checkOutput("refill_in_ready", in_ready, 4'b1011);
    for (int k = 0; k < 4; k++) begin
      pushExp(2'd2, drainVals[k]);
      applyStimulus(4'b0000, 8'h00, 4'b0100, 1'b1);
    end
    applyStimulus(4'b0000, 8'h00, 4'b0000, 1'b1);
    checkOutput("wrap_request_drained", request, 4'b0000);
    checkOutput("wrap_in_ready", in_ready, 4'b1111);
    checkOutput("wrap_err", err, 1'b0);

    $display("[TB] protocol errors");
    applyStimulus(4'b0011, 8'h60, 4'b0000, 1'b1);
    checkOutput("err_request_loaded", request, 4'b0011);
    applyStimulus(4'b0000, 8'h00, 4'b0011, 1'b1);
    checkOutput("multihot_no_pop", out_valid, 1'b0);
    checkOutput("multihot_err", err, 1'b1);
    applyStimulus(4'b0000, 8'h00, 4'b0100, 1'b1);
    checkOutput("badgrant_no_pop", out_valid, 1'b0);
    checkOutput("badgrant_request", request, 4'b0011);
    checkOutput("badgrant_err", err, 1'b1);
    applyStimulus(4'b0000, 8'h00, 4'b0000, 1'b1);
    checkOutput("err_sticky", err, 1'b1);
    pushExp(2'd0, 8'h60);
    applyStimulus(4'b0000, 8'h00, 4'b0001, 1'b0);
    checkOutput("pre_reset_out_valid", out_valid, 1'b1);
    checkOutput("pre_reset_out_data", out_data, 8'h60);
    checkOutput("pre_reset_err", err, 1'b1);

    $display("[TB] reset mid-operation");
    #2;
    rst_b = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_reset_out_valid", out_valid, 1'b0);
    checkOutput("async_reset_out_data", out_data, 8'h00);
    checkOutput("async_reset_err", err, 1'b0);
    checkOutput("async_reset_request", request, 4'b0000);
    step();
    @(negedge clk);
    rst_b = 1'b1;
    out_ready = 1'b1;
    grant = 4'b0000;
    step();
    checkOutput("post_reset_in_ready", in_ready, 4'b1111);
    checkOutput("post_reset_request", request, 4'b0000);
    checkOutput("post_reset_out_valid", out_valid, 1'b0);
    checkOutput("post_reset_err", err, 1'b0);

    step();
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
